amba_arbiter: RTL and testbench

AMBA_ARBITER -- requirements
Module: amba_arbiter

---
 rtl/amba_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_amba_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amba_arbiter.sv
// Two-master round-robin bus arbiter in front of a single locked-handshake slave.
// Master 0 is the instruction-fetch port, master 1 the data port. One
// transaction is in flight at a time; the command is held until the slave
// raises and then drops isLocked, or until the timeout counter expires.
module amba_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,

    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,

    output logic [31:0] Adress,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemData,
    input  logic        isLocked
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Last counter value before the abort fires, so ISSUE/WAIT last at most TIMEOUT cycles.
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t      state_q;
    logic        last_q;      // master granted most recently (1 = master 1)
    logic        gnt_q;       // master owning the current transaction
    logic        wr_q;        // current transaction direction (1 = write)
    logic [3:0]  tmo_q;

    logic        req0_s;
    logic        req1_s;
    logic        win_s;
    logic        wr_sel_s;
    logic [31:0] addr_sel_s;
    logic [31:0] wdata_sel_s;
    logic        tmo_hit_s;

    // Arbitration: a master whose done/err is showing this cycle is ignored so a
    // request that is still held while the master reacts is not served twice.
    always_comb begin
        req0_s = (m0_read | m0_write) & ~(m0_done | m0_err);
        req1_s = (m1_read | m1_write) & ~(m1_done | m1_err);
        if (req0_s && req1_s) begin
            win_s = ~last_q;
        end else if (req1_s) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            wr_sel_s    = m1_write;
            addr_sel_s  = m1_addr;
            wdata_sel_s = m1_wdata;
        end else begin
            wr_sel_s    = m0_write;
            addr_sel_s  = m0_addr;
            wdata_sel_s = m0_wdata;
        end
        tmo_hit_s = (tmo_q == TMO_LAST);
    end

    // Transaction FSM; every output is a register updated only on state transitions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            wr_q      <= 1'b0;
            tmo_q     <= 4'd0;
            Adress    <= 32'd0;
            WriteData <= 32'd0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
            m0_done   <= 1'b0;
            m0_err    <= 1'b0;
            m1_done   <= 1'b0;
            m1_err    <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m0_err  <= 1'b0;
            m1_done <= 1'b0;
            m1_err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0_s || req1_s) begin
                        gnt_q     <= win_s;
                        wr_q      <= wr_sel_s;
                        Adress    <= addr_sel_s;
                        WriteData <= wdata_sel_s;
                        MemWrite  <= wr_sel_s;
                        MemRead   <= ~wr_sel_s;
                        tmo_q     <= 4'd0;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (isLocked) begin
                        tmo_q   <= 4'd0;
                        state_q <= WAIT;
                    end else if (tmo_hit_s) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        if (gnt_q) begin
                            m1_err <= 1'b1;
                        end else begin
                            m0_err <= 1'b1;
                        end
                        last_q  <= gnt_q;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                WAIT: begin
                    if (!isLocked) begin
                        state_q <= DONE;
                    end else if (tmo_hit_s) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        if (gnt_q) begin
                            m1_err <= 1'b1;
                        end else begin
                            m0_err <= 1'b1;
                        end
                        last_q  <= gnt_q;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
                end
                DONE: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    if (gnt_q) begin
                        m1_done <= 1'b1;
                        if (!wr_q) begin
                            m1_rdata <= MemData;
                        end
                    end else begin
                        m0_done <= 1'b1;
                        if (!wr_q) begin
                            m0_rdata <= MemData;
                        end
                    end
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
                default: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amba_arbiter.sv
// Self-checking bench for amba_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model (latency = 3 + a + b).
module tb_amba_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic [31:0] Adress, WriteData, MemData;
    logic        MemRead, MemWrite, isLocked;

    int n_cmp = 0;
    int n_bad = 0;

    amba_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .Adress(Adress), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemData(MemData), .isLocked(isLocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_read = 1'b0; m1_write = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        MemData = 32'd0; isLocked = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({MemRead, MemWrite, m0_done, m0_err, m1_done, m1_err} !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_strobes got=%b exp=000000", {MemRead, MemWrite, m0_done, m0_err, m1_done, m1_err});
        end
        n_cmp++;
        if ({Adress, WriteData, m0_rdata, m1_rdata} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_data got=%h %h %h %h exp=0", Adress, WriteData, m0_rdata, m1_rdata);
        end
    endtask

    // m0 read, addr 15, isLocked high for edges 1..4, done after edge 6.
    task automatic test_read_m0();
        do_reset();
        m0_read = 1'b1; m0_addr = 32'd15;
        for (int e = 0; e <= 7; e++) begin
            isLocked = (e >= 1 && e <= 4);
            MemData  = (e == 6) ? 32'd2 : 32'hBAD0_0000 + 32'(e);
            tick();
            n_cmp++;
            if (MemRead !== (e < 6) || Adress !== 32'd15 || MemWrite !== 1'b0) begin
                n_bad++;
                $display("FAIL rd0_cmd e=%0d got MemRead=%b Adress=%0h MemWrite=%b exp MemRead=%b Adress=f", e, MemRead, Adress, MemWrite, e < 6);
            end
            n_cmp++;
            if (m0_done !== (e == 6) || m0_err !== 1'b0 || m1_done !== 1'b0) begin
                n_bad++;
                $display("FAIL rd0_done e=%0d got=%b%b%b exp=%b00", e, m0_done, m0_err, m1_done, e == 6);
            end
            if (m0_done) m0_read = 1'b0;
        end
        n_cmp++;
        if (m0_rdata !== 32'd2) begin
            n_bad++;
            $display("FAIL rd0_rdata got=%0h exp=2", m0_rdata);
        end
    endtask

    // m1 write addr 16 data 4; a=1, b=1 so done after edge 5.
    task automatic test_write_m1();
        do_reset();
        m1_write = 1'b1; m1_addr = 32'd16; m1_wdata = 32'd4;
        for (int e = 0; e <= 6; e++) begin
            isLocked = (e == 2 || e == 3);
            MemData  = 32'h5555_0000 + 32'(e);
            tick();
            n_cmp++;
            if (MemWrite !== (e < 5) || MemRead !== 1'b0 || Adress !== 32'd16 || WriteData !== 32'd4) begin
                n_bad++;
                $display("FAIL wr1_cmd e=%0d got MW=%b MR=%b A=%0h WD=%0h exp MW=%b MR=0 A=10 WD=4", e, MemWrite, MemRead, Adress, WriteData, e < 5);
            end
            n_cmp++;
            if (m1_done !== (e == 5) || m1_err !== 1'b0 || m0_done !== 1'b0) begin
                n_bad++;
                $display("FAIL wr1_done e=%0d got=%b%b%b exp=%b00", e, m1_done, m1_err, m0_done, e == 5);
            end
            if (m1_done) m1_write = 1'b0;
        end
        n_cmp++;
        if (m1_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL wr1_rdata got=%0h exp=0", m1_rdata);
        end
    endtask

    // Simultaneous reads after reset: m0 first, m1 after one idle cycle.
    task automatic test_round_robin();
        do_reset();
        m0_read = 1'b1; m0_addr = 32'h100;
        m1_read = 1'b1; m1_addr = 32'h200;
        for (int e = 0; e <= 8; e++) begin
            isLocked = (e == 1 || e == 5);
            MemData  = (e == 3) ? 32'h11 : (e == 7) ? 32'h22 : 32'hFFFF_0000 + 32'(e);
            tick();
            n_cmp++;
            if (MemRead !== ((e < 3) || (e >= 4 && e < 7)) || Adress !== ((e < 4) ? 32'h100 : 32'h200)) begin
                n_bad++;
                $display("FAIL rr_cmd e=%0d got MR=%b A=%0h", e, MemRead, Adress);
            end
            n_cmp++;
            if (m0_done !== (e == 3) || m1_done !== (e == 7)) begin
                n_bad++;
                $display("FAIL rr_done e=%0d got d0=%b d1=%b exp d0=%b d1=%b", e, m0_done, m1_done, e == 3, e == 7);
            end
            if (m0_done) m0_read = 1'b0;
            if (m1_done) m1_read = 1'b0;
        end
        n_cmp++;
        if (m0_rdata !== 32'h11 || m1_rdata !== 32'h22) begin
            n_bad++;
            $display("FAIL rr_rdata got=%0h %0h exp=11 22", m0_rdata, m1_rdata);
        end
    endtask

    // Slave never locks: command held 15 cycles, then m1_err pulses.
    task automatic test_timeout();
        do_reset();
        m1_read = 1'b1; m1_addr = 32'h40;
        for (int e = 0; e <= 16; e++) begin
            isLocked = 1'b0;
            MemData  = 32'h7777_0000 + 32'(e);
            tick();
            n_cmp++;
            if (MemRead !== (e < 15)) begin
                n_bad++;
                $display("FAIL tmo_cmd e=%0d got MR=%b exp=%b", e, MemRead, e < 15);
            end
            n_cmp++;
            if (m1_err !== (e == 15) || m1_done !== 1'b0 || m0_err !== 1'b0) begin
                n_bad++;
                $display("FAIL tmo_err e=%0d got err1=%b done1=%b err0=%b exp err1=%b", e, m1_err, m1_done, m0_err, e == 15);
            end
            if (m1_err) m1_read = 1'b0;
        end
        n_cmp++;
        if (m1_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL tmo_rdata got=%0h exp=0", m1_rdata);
        end
    endtask

    // Reset while in WAIT aborts silently; a later read completes normally.
    task automatic test_reset_mid();
        do_reset();
        m0_read = 1'b1; m0_addr = 32'h20;
        for (int e = 0; e <= 2; e++) begin
            isLocked = (e >= 1);
            tick();
        end
        n_cmp++;
        if (MemRead !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre got MR=%b exp=1", MemRead);
        end
        rst_n = 1'b0; m0_read = 1'b0;
        tick();
        rst_n = 1'b1; isLocked = 1'b0;
        for (int e = 0; e <= 1; e++) begin
            n_cmp++;
            if ({MemRead, m0_done, m0_err, m1_done, m1_err} !== 5'd0) begin
                n_bad++;
                $display("FAIL rstmid_abort step=%0d got=%b exp=00000", e, {MemRead, m0_done, m0_err, m1_done, m1_err});
            end
            tick();
        end
        m0_read = 1'b1; m0_addr = 32'h44;
        for (int e = 0; e <= 4; e++) begin
            isLocked = (e == 1);
            MemData  = (e == 3) ? 32'hCAFE_F00D : 32'h0;
            tick();
            n_cmp++;
            if (m0_done !== (e == 3) || m0_err !== 1'b0 || MemRead !== (e < 3)) begin
                n_bad++;
                $display("FAIL rstmid_new e=%0d got done=%b err=%b MR=%b exp done=%b MR=%b", e, m0_done, m0_err, MemRead, e == 3, e < 3);
            end
            if (m0_done) m0_read = 1'b0;
        end
        n_cmp++;
        if (m0_rdata !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL rstmid_rdata got=%0h exp=cafef00d", m0_rdata);
        end
    endtask

    // Read and write together: write wins.
    task automatic test_rw_both();
        do_reset();
        m0_read = 1'b1; m0_write = 1'b1; m0_addr = 32'h30; m0_wdata = 32'hA5;
        for (int e = 0; e <= 5; e++) begin
            isLocked = (e == 1 || e == 2);
            MemData  = 32'h9999_0000 + 32'(e);
            tick();
            n_cmp++;
            if (MemWrite !== (e < 4) || MemRead !== 1'b0 || WriteData !== 32'hA5) begin
                n_bad++;
                $display("FAIL rw_cmd e=%0d got MW=%b MR=%b WD=%0h exp MW=%b MR=0 WD=a5", e, MemWrite, MemRead, WriteData, e < 4);
            end
            n_cmp++;
            if (m0_done !== (e == 4)) begin
                n_bad++;
                $display("FAIL rw_done e=%0d got=%b exp=%b", e, m0_done, e == 4);
            end
            if (m0_done) begin
                m0_read = 1'b0; m0_write = 1'b0;
            end
        end
        n_cmp++;
        if (m0_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL rw_rdata got=%0h exp=0", m0_rdata);
        end
    endtask

    // Randomized traffic against a transaction-level model.
    task automatic test_random();
        logic [31:0] addr [2];
        logic [31:0] wd [2];
        logic [31:0] md [2];
        logic [31:0] exp_rd [2];
        logic        wr [2];
        logic        rd [2];
        logic        req [2];
        logic        exp_dn [2];
        int          a [2];
        int          b [2];
        int          s [2];
        int          d [2];
        int          ord [2];
        int          pat, ntx, end_e, last, m;
        logic        early, exp_mr, exp_mw;
        logic [31:0] exp_ad, exp_wd;

        do_reset();
        exp_ad = 32'd0; exp_wd = 32'd0; exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        last = 1;
        for (int it = 0; it < 25; it++) begin
            pat = int'($urandom_range(2, 0));
            for (int k = 0; k < 2; k++) begin
                addr[k] = $urandom; wd[k] = $urandom; md[k] = $urandom;
                wr[k] = 1'($urandom_range(1, 0));
                rd[k] = wr[k] ? 1'($urandom_range(1, 0)) : 1'b1;
                a[k] = int'($urandom_range(4, 0));
                b[k] = int'($urandom_range(4, 0));
            end
            req[0] = (pat != 1);
            req[1] = (pat != 0);
            if (pat == 2) ord[0] = (last == 1) ? 0 : 1;
            else          ord[0] = (pat == 0) ? 0 : 1;
            ord[1] = 1 - ord[0];
            ntx = (pat == 2) ? 2 : 1;
            s[ord[0]] = 0;
            d[ord[0]] = 3 + a[ord[0]] + b[ord[0]];
            s[ord[1]] = d[ord[0]] + 1;
            d[ord[1]] = s[ord[1]] + 3 + a[ord[1]] + b[ord[1]];
            end_e = d[ord[ntx - 1]] + 1;
            early = 1'($urandom_range(1, 0));
            for (int e = 0; e <= end_e; e++) begin
                m0_read = req[0] & rd[0]; m0_write = req[0] & wr[0];
                m0_addr = addr[0];        m0_wdata = wd[0];
                m1_read = req[1] & rd[1]; m1_write = req[1] & wr[1];
                m1_addr = addr[1];        m1_wdata = wd[1];
                isLocked = 1'($urandom_range(1, 0));
                MemData  = $urandom;
                for (int k = 0; k < ntx; k++) begin
                    m = ord[k];
                    if (e > s[m] && e < d[m])
                        isLocked = (e >= s[m] + a[m] + 1) && (e <= s[m] + a[m] + b[m] + 1);
                    if (e == d[m]) MemData = md[m];
                end
                tick();
                exp_mr = 1'b0; exp_mw = 1'b0; exp_dn[0] = 1'b0; exp_dn[1] = 1'b0;
                for (int k = 0; k < ntx; k++) begin
                    m = ord[k];
                    if (e >= s[m] && e < d[m]) begin
                        exp_mr = ~wr[m]; exp_mw = wr[m];
                    end
                    if (e == s[m]) begin
                        exp_ad = addr[m]; exp_wd = wd[m];
                    end
                    if (e == d[m]) begin
                        exp_dn[m] = 1'b1;
                        if (!wr[m]) exp_rd[m] = md[m];
                        last = m;
                    end
                end
                n_cmp++;
                if (MemRead !== exp_mr || MemWrite !== exp_mw) begin
                    n_bad++;
                    $display("FAIL rnd_cmd it=%0d e=%0d got MR=%b MW=%b exp MR=%b MW=%b", it, e, MemRead, MemWrite, exp_mr, exp_mw);
                end
                n_cmp++;
                if (Adress !== exp_ad || WriteData !== exp_wd) begin
                    n_bad++;
                    $display("FAIL rnd_bus it=%0d e=%0d got A=%h WD=%h exp A=%h WD=%h", it, e, Adress, WriteData, exp_ad, exp_wd);
                end
                n_cmp++;
                if (m0_done !== exp_dn[0] || m1_done !== exp_dn[1] || m0_err !== 1'b0 || m1_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rnd_done it=%0d e=%0d got d0=%b d1=%b e0=%b e1=%b exp d0=%b d1=%b e=00", it, e, m0_done, m1_done, m0_err, m1_err, exp_dn[0], exp_dn[1]);
                end
                n_cmp++;
                if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
                    n_bad++;
                    $display("FAIL rnd_rdata it=%0d e=%0d got %h %h exp %h %h", it, e, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
                end
                for (int k = 0; k < 2; k++) begin
                    if (exp_dn[k]) req[k] = 1'b0;
                end
                if (early && e == s[ord[0]]) req[ord[0]] = 1'b0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_read_m0();
        test_write_m1();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_rw_both();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
